// File: rtl/k_means_apb_master.sv
// APB master for the k-means register file: queues commands in a small FIFO and
// issues them one at a time as APB transfers, with a pready timeout per transfer.
module k_means_apb_master #(
   parameter int addrWidth  = 8,
   parameter int dataWidth  = 91,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [addrWidth-1:0] cmd_addr,
   input  logic [dataWidth-1:0] cmd_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [dataWidth-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic [addrWidth-1:0] paddr,
   output logic                 pwrite,
   output logic                 psel,
   output logic                 penable,
   output logic [dataWidth-1:0] pwdata,
   input  logic [dataWidth-1:0] prdata,
   input  logic                 pready,
   output logic                 busy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

   state_t               state_r, state_s;
   logic [addrWidth-1:0] fifo_addr_r  [FIFO_DEPTH];
   logic                 fifo_write_r [FIFO_DEPTH];
   logic [dataWidth-1:0] fifo_wdata_r [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]     count_r, count_s;
   logic [TO_W-1:0]      to_cnt_r;
   logic                 push_s, pop_s, load_s, capture_s, expire_s, timeout_s;
   logic [addrWidth-1:0] paddr_r;
   logic                 pwrite_r, psel_r, penable_r;
   logic [dataWidth-1:0] pwdata_r, rsp_rdata_r;
   logic                 rsp_valid_r, rsp_err_r, busy_r, cmd_ready_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (count_r != CNT_W'(0)) state_s = SETUP;
            else                      state_s = IDLE;
         end
         SETUP: state_s = ACCESS;
         ACCESS: begin
            if (pready)         state_s = pwrite_r ? IDLE : RESP;
            else if (timeout_s) state_s = RESP;
            else                state_s = ACCESS;
         end
         RESP: begin
            if (rsp_ready) state_s = IDLE;
            else           state_s = RESP;
         end
         default: state_s = IDLE;
      endcase
   end

   // Control decode: FIFO push/pop, head load, response capture
   always_comb begin
      push_s    = cmd_valid && cmd_ready_r;
      timeout_s = (to_cnt_r == TO_W'(TIMEOUT - 1));
      load_s    = 1'b0;
      pop_s     = 1'b0;
      capture_s = 1'b0;
      expire_s  = 1'b0;
      case (state_r)
         IDLE: load_s = (count_r != CNT_W'(0));
         ACCESS: begin
            pop_s     = pready || timeout_s;
            capture_s = pready && !pwrite_r;
            expire_s  = !pready && timeout_s;
         end
         default: load_s = 1'b0;
      endcase
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CNT_W'(1);
         2'b01:   count_s = count_r - CNT_W'(1);
         default: count_s = count_r;
      endcase
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_addr_r[wr_ptr_r]  <= cmd_addr;
         fifo_write_r[wr_ptr_r] <= cmd_write;
         fifo_wdata_r[wr_ptr_r] <= cmd_wdata;
      end
   end

   // FIFO pointers, occupancy and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r    <= PTR_W'(0);
         rd_ptr_r    <= PTR_W'(0);
         count_r     <= CNT_W'(0);
         busy_r      <= 1'b0;
         cmd_ready_r <= 1'b1;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         count_r     <= count_s;
         busy_r      <= (count_s != CNT_W'(0)) || (state_s != IDLE);
         cmd_ready_r <= (count_s != CNT_W'(FIFO_DEPTH));
      end
   end

   // APB outputs; address/data latched from the head on the way into SETUP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paddr_r   <= '0;
         pwrite_r  <= 1'b0;
         pwdata_r  <= '0;
         psel_r    <= 1'b0;
         penable_r <= 1'b0;
         to_cnt_r  <= TO_W'(0);
      end else begin
         if (load_s) begin
            paddr_r  <= fifo_addr_r[rd_ptr_r];
            pwrite_r <= fifo_write_r[rd_ptr_r];
            pwdata_r <= fifo_wdata_r[rd_ptr_r];
         end
         psel_r    <= (state_s == SETUP) || (state_s == ACCESS);
         penable_r <= (state_s == ACCESS);
         if (load_s)                 to_cnt_r <= TO_W'(0);
         else if (state_r == ACCESS) to_cnt_r <= to_cnt_r + TO_W'(1);
      end
   end

   // Response register, held stable while RESP waits for rsp_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= '0;
         rsp_err_r   <= 1'b0;
      end else begin
         rsp_valid_r <= (state_s == RESP);
         if (capture_s) begin
            rsp_rdata_r <= prdata;
            rsp_err_r   <= 1'b0;
         end else if (expire_s) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b1;
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign busy      = busy_r;
   assign paddr     = paddr_r;
   assign pwrite    = pwrite_r;
   assign pwdata    = pwdata_r;
   assign psel      = psel_r;
   assign penable   = penable_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_k_means_apb_master.sv
// Bench for k_means_apb_master: APB slave model and response consumer check
// against queues of expectations pushed when each command is accepted.
module tb_k_means_apb_master;
   localparam int AW = 8;
   localparam int DW = 91;
   localparam int TO = 255;

   logic          clk, rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr, paddr;
   logic [DW-1:0] cmd_wdata, rsp_rdata, pwdata, prdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic          pwrite, psel, penable, pready, busy;

   k_means_apb_master #(.addrWidth(AW), .dataWidth(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            delay;
      logic [DW-1:0] prdata;
   } apb_exp_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_exp_t;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            delay;
      logic [DW-1:0] prdata;
      logic          exp_rsp;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   apb_exp_t apb_q[$];
   rsp_exp_t rsp_q[$];
   int total = 0;
   int bad = 0;
   int rsp_hold = 0;
   int rsp_seen = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // delay = ACCESS cycles with pready low before the pready cycle; >= TO never completes
   function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int dl, input logic [DW-1:0] pr);
      vec_t v;
      v.write     = w;
      v.addr      = a;
      v.wdata     = d;
      v.delay     = dl;
      v.prdata    = pr;
      v.exp_rsp   = !w || (dl >= TO);
      v.exp_rdata = (dl >= TO) ? '0 : pr;
      v.exp_err   = (dl >= TO);
      return v;
   endfunction

   task automatic push_cmd(input vec_t v, output int waited);
      apb_exp_t e;
      rsp_exp_t r;
      waited = 0;
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      while (!cmd_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check("push_ready_wait", cmd_ready, 1'b1);
         cmd_valid = 1'b0;
      end else begin
         e.write = v.write; e.addr = v.addr; e.wdata = v.wdata; e.delay = v.delay; e.prdata = v.prdata;
         apb_q.push_back(e);
         if (v.exp_rsp) begin
            r.rdata = v.exp_rdata;
            r.err   = v.exp_err;
            rsp_q.push_back(r);
         end
         @(posedge clk);
         @(negedge clk);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || rsp_valid || rsp_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_busy", busy, 1'b0);
      check("drain_rsp_q", rsp_q.size(), 0);
      check("drain_apb_q", apb_q.size(), 0);
   endtask

   // APB slave model: checks issue order and drives pready per expected delay
   initial begin
      apb_exp_t cur;
      int acc_n = 0;
      cur = '{1'b0, '0, '0, 0, '0};
      pready = 1'b0;
      prdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pready = 1'b0;
            acc_n = 0;
         end else if (psel && !penable) begin
            if (apb_q.size() == 0) begin
               check("apb_unexpected_psel", psel, 1'b0);
            end else begin
               cur = apb_q.pop_front();
               check("apb_paddr", paddr, cur.addr);
               check("apb_pwrite", pwrite, cur.write);
               if (cur.write) check("apb_pwdata", pwdata, cur.wdata);
            end
            pready = 1'b0;
            acc_n = 0;
         end else if (psel && penable) begin
            check("apb_paddr_hold", paddr, cur.addr);
            pready = (acc_n == cur.delay);
            prdata = pready ? cur.prdata : ~cur.prdata;
            acc_n++;
         end else begin
            pready = 1'b0;
         end
      end
   end

   // Response consumer: compares every cycle rsp_valid is up, accepts after rsp_hold cycles
   initial begin
      int hold = 0;
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || !rsp_valid) begin
            rsp_ready = 1'b0;
            hold = 0;
         end else if (rsp_q.size() == 0) begin
            check("rsp_unexpected", rsp_valid, 1'b0);
            rsp_ready = 1'b1;
            rsp_seen++;
         end else begin
            check("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
            check("rsp_err", rsp_err, rsp_q[0].err);
            if (hold < rsp_hold) begin
               rsp_ready = 1'b0;
               hold++;
            end else begin
               rsp_ready = 1'b1;
               void'(rsp_q.pop_front());
               rsp_seen++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      vec_t tbl[8];
      vec_t v;
      int w, n, guard, seen0;

      tbl[0] = mk(1'b1, 8'h02, 91'h7FF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 91'h0);
      tbl[1] = mk(1'b0, 8'h04, 91'h0, 1, 91'h4_0000_0000_0000_0000_0001);
      tbl[2] = mk(1'b1, 8'h80, 91'h1, 3, 91'h0);
      tbl[3] = mk(1'b0, 8'hFF, 91'h0, 0, 91'h0);
      tbl[4] = mk(1'b0, 8'h00, 91'h0, 2, 91'hDEAD_BEEF_CAFE_F00D);
      tbl[5] = mk(1'b1, 8'h55, 91'h2AA_AAAA_AAAA_AAAA_AAAA_AAAA, 1, 91'h0);
      tbl[6] = mk(1'b0, 8'hAA, 91'h0, 0, 91'h7FF_FFFF_FFFF_FFFF_FFFF_FFFF);
      tbl[7] = mk(1'b1, 8'h7F, 91'h0, 0, 91'h0);

      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;

      // reset state
      @(negedge clk);
      check("rst_psel", psel, 1'b0);
      check("rst_penable", penable, 1'b0);
      check("rst_paddr", paddr, 8'h00);
      check("rst_pwrite", pwrite, 1'b0);
      check("rst_pwdata", pwdata, 91'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 91'h0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_cmd_ready", cmd_ready, 1'b1);
      check("rel_busy", busy, 1'b0);

      // single write, exact cycle timing
      push_cmd(mk(1'b1, 8'h01, 91'h5A, 0, 91'h0), w);
      check("wr_c1_psel", psel, 1'b0);
      @(negedge clk);
      check("wr_c2_psel", psel, 1'b1);
      check("wr_c2_penable", penable, 1'b0);
      check("wr_c2_paddr", paddr, 8'h01);
      @(negedge clk);
      check("wr_c3_penable", penable, 1'b1);
      check("wr_c3_pwdata", pwdata, 91'h5A);
      @(negedge clk);
      check("wr_c4_psel", psel, 1'b0);
      check("wr_c4_rsp_valid", rsp_valid, 1'b0);
      check("wr_c4_busy", busy, 1'b0);
      wait_idle();

      // single read, response held 3 cycles
      rsp_hold = 3;
      push_cmd(mk(1'b0, 8'h03, 91'h0, 0, 91'h123), w);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rd_c4_rsp_valid", rsp_valid, 1'b1);
      check("rd_c4_rsp_rdata", rsp_rdata, 91'h123);
      check("rd_c4_rsp_err", rsp_err, 1'b0);
      wait_idle();
      rsp_hold = 0;

      // table vectors back-to-back
      for (int i = 0; i < 8; i++) push_cmd(tbl[i], w);
      wait_idle();

      // FIFO full: 5th push stalls until first pop
      push_cmd(mk(1'b1, 8'h10, 91'h10, 10, 91'h0), w);
      for (int i = 1; i < 4; i++) push_cmd(mk(1'b0, AW'(8'h10 + i), 91'h0, 0, DW'(i * 7)), w);
      check("full_cmd_ready", cmd_ready, 1'b0);
      check("full_busy", busy, 1'b1);
      push_cmd(mk(1'b1, 8'h14, 91'h14, 0, 91'h0), w);
      check("fifth_wait_cycles", w, 10);
      wait_idle();

      // push coinciding with pop at count 3
      push_cmd(mk(1'b1, 8'h30, 91'h30, 2, 91'h0), w);
      push_cmd(mk(1'b1, 8'h31, 91'h31, 0, 91'h0), w);
      push_cmd(mk(1'b1, 8'h32, 91'h32, 0, 91'h0), w);
      @(negedge clk);
      @(negedge clk);
      push_cmd(mk(1'b1, 8'h33, 91'h33, 0, 91'h0), w);
      check("pushpop_cmd_ready", cmd_ready, 1'b1);
      push_cmd(mk(1'b1, 8'h34, 91'h34, 0, 91'h0), w);
      check("pushpop_then_full", cmd_ready, 1'b0);
      wait_idle();

      // read and write timeouts
      for (int k = 0; k < 2; k++) begin
         v = mk(k[0], 8'h20, 91'h77, 1000, 91'h3);
         push_cmd(v, w);
         n = 0;
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
            if (psel && penable) n++;
         end while (!(n > 0 && !(psel && penable)) && guard < 400);
         check("to_access_cycles", n, TO);
         check("to_psel_dropped", psel, 1'b0);
         check("to_rsp_valid", rsp_valid, 1'b1);
         check("to_rsp_err", rsp_err, 1'b1);
         check("to_rsp_rdata", rsp_rdata, 91'h0);
         wait_idle();
      end

      // reset during ACCESS with 3 queued commands
      push_cmd(mk(1'b0, 8'h40, 91'h0, 1000, 91'h9), w);
      for (int i = 1; i < 4; i++) push_cmd(mk(1'b1, AW'(8'h40 + i), DW'(i), 0, 91'h0), w);
      guard = 0;
      while (!(psel && penable) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("rstmid_in_access", penable, 1'b1);
      seen0 = rsp_seen;
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_psel", psel, 1'b0);
      check("rstmid_penable", penable, 1'b0);
      apb_q.delete();
      rsp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_cmd_ready", cmd_ready, 1'b1);
      check("rstmid_psel_after", psel, 1'b0);
      check("rstmid_no_rsp", rsp_seen, seen0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/k_means_apb_master.md
K_MEANS_APB_MASTER -- requirements
Module: k_means_apb_master

Interface
REQ-001 Parameter addrWidth, default 8, APB address width.
REQ-002 Parameter dataWidth, default 91, APB data width.
REQ-003 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-004 Parameter TIMEOUT, default 255, max ACCESS cycles waiting for pready.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command FIFO can accept.
REQ-009 cmd_write  input  1  1=APB write, 0=APB read.
REQ-010 cmd_addr  input  addrWidth  target register address.
REQ-011 cmd_wdata  input  dataWidth  write data (ignored for reads).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_rdata  output  dataWidth  read data; zero for timed-out transfers.
REQ-015 rsp_err  output  1  1 = transfer timed out.
REQ-016 paddr, pwrite, psel, penable, pwdata  output  addrWidth/1/1/1/dataWidth  APB master signals to the k-means register file.
REQ-017 prdata  input  dataWidth; pready  input  1  APB slave returns.
REQ-018 busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-019 Command accepted on an edge where cmd_valid && cmd_ready; cmd_ready = (count != FIFO_DEPTH), with no full-bypass.
REQ-020 FIFO: registered, FIFO_DEPTH-deep, wrap-around pointers, count width clog2(FIFO_DEPTH)+1; simultaneous push and pop leaves count unchanged.
REQ-021 FSM states IDLE, SETUP, ACCESS, RESP.
REQ-022 IDLE: count>0 -> SETUP; otherwise stay.
REQ-023 SETUP: psel=1, penable=0, paddr/pwrite/pwdata from FIFO head; always -> ACCESS next cycle.
REQ-024 ACCESS: psel=1, penable=1, same paddr/pwrite/pwdata; timeout counter increments each cycle.
REQ-025 ACCESS with pready=1: pop the FIFO head; a read captures prdata into rsp_rdata, sets rsp_err=0, and -> RESP; a write -> IDLE with no response.
REQ-026 ACCESS with pready=0 and counter == TIMEOUT-1: drop psel/penable, pop, rsp_rdata=0, rsp_err=1, -> RESP (applies to reads and writes).
REQ-027 RESP: rsp_valid=1 with rsp_rdata/rsp_err held stable until rsp_ready=1; that edge -> IDLE.
REQ-028 Latency: a command accepted in cycle C0 into an empty idle block gives SETUP in C2 and ACCESS in C3; a read with pready in C3 gives rsp_valid in C4.
REQ-029 Outside SETUP/ACCESS: psel=0, penable=0; paddr/pwrite/pwdata hold their last values.
REQ-030 Timeout counter clears on entry to SETUP; it is 8 bits minimum, sized clog2(TIMEOUT+1).
REQ-031 Commands may be pushed in any state, including RESP and ACCESS.
REQ-032 Transfers are strictly in order; at most one outstanding APB transfer.

Reset
REQ-033 rst_n low asynchronously forces: FSM IDLE, FIFO empty, count 0, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter 0, busy=0; cmd_ready=1 after release.
REQ-034 Reset mid-transfer abandons the transfer and all queued commands; no response is produced.

Verification
REQ-035 Write addr 0x01 data 0x5A with pready=1 in the first ACCESS cycle -> psel C2, penable C3, paddr=0x01, pwdata=0x5A, no rsp_valid, busy low in C4.
REQ-036 Read addr 0x03 with pready=1, prdata=0x123 -> rsp_valid in C4, rsp_rdata=0x123, rsp_err=0, held while rsp_ready=0 for 3 cycles.
REQ-037 Push 5 commands back-to-back with pready=0 -> cmd_ready low after the 4th; the 5th is accepted only after the first pop; APB addresses are issued in push order.
REQ-038 Read with pready held 0 and TIMEOUT=255 -> psel drops after 255 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-039 Assert rst_n=0 during ACCESS with 3 queued commands -> psel and penable are 0 immediately; after release, busy=0, cmd_ready=1, and no response is produced.
REQ-040 Push a command in the same edge as a pop while the FIFO is full-1 -> count is unchanged and data integrity is preserved.
